// File: rtl/ft245_emu_pkg.sv
// Shared types and constants for the FT245BM host-side emulator.
package ft245_emu_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_GAP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_CAPT, W_GAP} wr_state_t;

endpackage

// File: rtl/ft_sync_fifo.sv
// Single-clock FIFO with a registered head word and registered full/empty flags.
module ft_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr, rd_ptr_inc, rd_ptr_nxt, wr_ptr_nxt;
    logic             push_ok_c, pop_ok_c, full_nxt_c, empty_nxt_c;

    always_comb begin
        push_ok_c   = push && !full;
        pop_ok_c    = pop && !empty;
        rd_ptr_inc  = rd_ptr + PW'(1);
        rd_ptr_nxt  = pop_ok_c ? rd_ptr_inc : rd_ptr;
        wr_ptr_nxt  = push_ok_c ? (wr_ptr + PW'(1)) : wr_ptr;
        empty_nxt_c = (rd_ptr_nxt == wr_ptr_nxt);
        full_nxt_c  = (rd_ptr_nxt[AW-1:0] == wr_ptr_nxt[AW-1:0]) &&
                      (rd_ptr_nxt[AW] != wr_ptr_nxt[AW]);
    end

    always_ff @(posedge CLK) begin
        if (push_ok_c) mem[wr_ptr[AW-1:0]] <= din;
    end

    // full resets high so nothing is accepted until the first clock after reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            head   <= '0;
            full   <= 1'b1;
            empty  <= 1'b1;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            full   <= full_nxt_c;
            empty  <= empty_nxt_c;
            if (push_ok_c && (empty || (pop_ok_c && rd_ptr_inc == wr_ptr)))
                head <= din;
            else if (pop_ok_c && rd_ptr_inc != wr_ptr)
                head <= mem[rd_ptr_inc[AW-1:0]];
        end
    end

endmodule

// File: rtl/ft245_host_emu.sv
// FT245BM pin-level emulator: host byte streams on one side, nRXF/nTXE/nRD/WR/D on the other.
// Optional byte counters are enabled with FT245_EMU_STATS_EN.
module ft245_host_emu #(
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned RXF_GAP        = 2,
    parameter int unsigned TXE_GAP        = 2,
    parameter int unsigned WR_CAPTURE_DLY = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] host_rx_data,
    input  logic       host_rx_valid,
    output logic       host_rx_ready,
    output logic [7:0] host_tx_data,
    output logic       host_tx_valid,
    input  logic       host_tx_ready,
    output logic       nRXF,
    output logic       nTXE,
    input  logic       nRD,
    input  logic       WR,
    inout  wire  [7:0] D,
    output logic       proto_err
`ifdef FT245_EMU_STATS_EN
    ,
    output logic [15:0] rx_byte_count,
    output logic [15:0] tx_byte_count
`endif
);
    import ft245_emu_pkg::*;

    localparam int unsigned RG_W  = (RXF_GAP > 1) ? $clog2(RXF_GAP) : 1;
    localparam int unsigned TG_W  = (TXE_GAP > 1) ? $clog2(TXE_GAP) : 1;
    localparam int unsigned CAP_W = 2;

    logic [SYNC_STAGES-1:0] nrd_sync, wr_sync;
    logic                   nrd_q, wr_q, nrd_s, wr_s;
    logic                   nrd_fall_c, nrd_rise_c, wr_fall_c;

    rd_state_t        rd_state, rd_next;
    wr_state_t        wr_state, wr_next;
    logic [RG_W-1:0]  rd_gap_cnt, rd_gap_nxt;
    logic [TG_W-1:0]  wr_gap_cnt, wr_gap_nxt;
    logic [CAP_W-1:0] wr_cap_cnt, wr_cap_nxt;
    logic             rd_block, rd_block_nxt;
    logic             rx_pop_c, tx_push_c, rd_err_c;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]       rx_head;

    assign nrd_s      = nrd_sync[SYNC_STAGES-1];
    assign wr_s       = wr_sync[SYNC_STAGES-1];
    assign nrd_fall_c = nrd_q && !nrd_s;
    assign nrd_rise_c = !nrd_q && nrd_s;
    assign wr_fall_c  = wr_q && !wr_s;

    assign host_rx_ready = !rx_full;
    assign host_tx_valid = !tx_empty;

    // D is released in the same cycle the nRD rising edge is seen.
    assign D = (rd_state == R_DRIVE && !nrd_rise_c) ? rx_head : 8'bz;

    ft_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (host_rx_valid),
        .din   (host_rx_data),
        .pop   (rx_pop_c),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    ft_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (tx_push_c),
        .din   (D),
        .pop   (host_tx_ready),
        .head  (host_tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Read FSM; an empty-FIFO strobe is flagged once and then ignored until nRD returns high.
    always_comb begin
        rd_next      = rd_state;
        rd_gap_nxt   = rd_gap_cnt;
        rd_block_nxt = rd_block && !nrd_s;
        rx_pop_c     = 1'b0;
        rd_err_c     = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (!nrd_s && !rd_block) begin
                    if (!rx_empty) begin
                        rd_next = R_DRIVE;
                    end else begin
                        rd_err_c     = 1'b1;
                        rd_block_nxt = 1'b1;
                    end
                end
            end
            R_DRIVE: begin
                if (nrd_rise_c) begin
                    rx_pop_c   = 1'b1;
                    rd_next    = R_GAP;
                    rd_gap_nxt = '0;
                end
            end
            R_GAP: begin
                if (rd_gap_cnt == RG_W'(RXF_GAP - 1)) rd_next = R_IDLE;
                else rd_gap_nxt = rd_gap_cnt + RG_W'(1);
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Write FSM; a WR falling edge seen while nRD is low loses to the read.
    always_comb begin
        wr_next    = wr_state;
        wr_gap_nxt = wr_gap_cnt;
        wr_cap_nxt = wr_cap_cnt;
        tx_push_c  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (wr_fall_c && nrd_s) begin
                    if (WR_CAPTURE_DLY == 0) begin
                        tx_push_c  = 1'b1;
                        wr_next    = W_GAP;
                        wr_gap_nxt = '0;
                    end else begin
                        wr_next    = W_CAPT;
                        wr_cap_nxt = CAP_W'(1);
                    end
                end
            end
            W_CAPT: begin
                if (wr_cap_cnt == CAP_W'(WR_CAPTURE_DLY)) begin
                    tx_push_c  = 1'b1;
                    wr_next    = W_GAP;
                    wr_gap_nxt = '0;
                end else begin
                    wr_cap_nxt = wr_cap_cnt + CAP_W'(1);
                end
            end
            W_GAP: begin
                if (wr_gap_cnt == TG_W'(TXE_GAP - 1)) wr_next = W_IDLE;
                else wr_gap_nxt = wr_gap_cnt + TG_W'(1);
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            nrd_sync   <= '1;
            wr_sync    <= '0;
            nrd_q      <= 1'b1;
            wr_q       <= 1'b0;
            rd_state   <= R_IDLE;
            wr_state   <= W_IDLE;
            rd_gap_cnt <= '0;
            wr_gap_cnt <= '0;
            wr_cap_cnt <= '0;
            rd_block   <= 1'b0;
            nRXF       <= 1'b1;
            nTXE       <= 1'b1;
            proto_err  <= 1'b0;
        end else begin
            nrd_sync   <= {nrd_sync[SYNC_STAGES-2:0], nRD};
            wr_sync    <= {wr_sync[SYNC_STAGES-2:0], WR};
            nrd_q      <= nrd_s;
            wr_q       <= wr_s;
            rd_state   <= rd_next;
            wr_state   <= wr_next;
            rd_gap_cnt <= rd_gap_nxt;
            wr_gap_cnt <= wr_gap_nxt;
            wr_cap_cnt <= wr_cap_nxt;
            rd_block   <= rd_block_nxt;
            nRXF       <= rx_empty || (rd_state != R_IDLE);
            nTXE       <= tx_full || (wr_state != W_IDLE);
            proto_err  <= proto_err || rd_err_c || (tx_push_c && tx_full) || (!nrd_s && wr_s);
        end
    end

`ifdef FT245_EMU_STATS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_byte_count <= '0;
            tx_byte_count <= '0;
        end else begin
            if (rx_pop_c) rx_byte_count <= rx_byte_count + 16'd1;
            if (tx_push_c && !tx_full) tx_byte_count <= tx_byte_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ft245_host_emu.sv
// Directed bench for ft245_host_emu: host push/read strobes, bridge writes/host drain, errors, reset.
module tb_ft245_host_emu;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic       nRXF, nTXE, nRD, WR, proto_err;
    wire  [7:0] D;
    logic [7:0] d_drv;
    logic       d_en;
`ifdef FT245_EMU_STATS_EN
    logic [15:0] rx_byte_count, tx_byte_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Released bus floats to 8'hFF through the pullups.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (D[g]);
    end
    assign D = d_en ? d_drv : 8'bz;

    always #5 CLK = ~CLK;

    ft245_host_emu dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .nRXF          (nRXF),
        .nTXE          (nTXE),
        .nRD           (nRD),
        .WR            (WR),
        .D             (D),
        .proto_err     (proto_err)
`ifdef FT245_EMU_STATS_EN
        ,
        .rx_byte_count (rx_byte_count),
        .tx_byte_count (tx_byte_count)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(2);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
        nRD = 1'b0;
        tick(3);
        check(tag, 16'(D), 16'(exp));
        nRD = 1'b1;
        tick(6);
    endtask

    task automatic write_byte(input logic [7:0] val);
        d_drv = val;
        d_en  = 1'b1;
        WR    = 1'b1;
        tick(3);
        WR = 1'b0;
        tick(5);
        d_en = 1'b0;
        tick(4);
    endtask

    initial begin
        RESET = 1'b1; host_rx_data = '0; host_rx_valid = 1'b0; host_tx_ready = 1'b0;
        nRD = 1'b1; WR = 1'b0; d_drv = '0; d_en = 1'b0;

        // Reset state
        tick(3);
        check("rst_nrxf", 16'(nRXF), 16'd1);
        check("rst_ntxe", 16'(nTXE), 16'd1);
        check("rst_txvalid", 16'(host_tx_valid), 16'd0);
        check("rst_txdata", 16'(host_tx_data), 16'h0000);
        check("rst_err", 16'(proto_err), 16'd0);
        check("rst_rxready", 16'(host_rx_ready), 16'd0);
        check("rst_d", 16'(D), 16'h00FF);
        RESET = 1'b0;
        tick(1);
        check("rel_rxready", 16'(host_rx_ready), 16'd1);
        tick(1);
        check("rel_ntxe", 16'(nTXE), 16'd0);

        // Single byte A5: nRXF latency, drive window, release, gap
        host_rx_data = 8'hA5; host_rx_valid = 1'b1;
        tick(1);
        host_rx_valid = 1'b0;
        check("a5_nrxf_lat", 16'(nRXF), 16'd1);
        tick(1);
        check("a5_nrxf_low", 16'(nRXF), 16'd0);
        nRD = 1'b0;
        tick(3);
        check("a5_d0", 16'(D), 16'h00A5);
        tick(1);
        check("a5_d1", 16'(D), 16'h00A5);
        nRD = 1'b1;
        tick(1);
        check("a5_d2", 16'(D), 16'h00A5);
        tick(2);
        check("a5_d_rel", 16'(D), 16'h00FF);
        check("a5_nrxf_gap0", 16'(nRXF), 16'd1);
        tick(1);
        check("a5_nrxf_gap1", 16'(nRXF), 16'd1);
        tick(3);
        check("a5_nrxf_empty", 16'(nRXF), 16'd1);
        check("a5_err", 16'(proto_err), 16'd0);

        // Fill RX with 0..15, refuse a 17th, read back in order
        host_rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            host_rx_data = 8'(i);
            tick(1);
        end
        check("rx_full_rdy", 16'(host_rx_ready), 16'd0);
        host_rx_data = 8'hEE;
        tick(2);
        host_rx_valid = 1'b0;
        check("rx_17_rdy", 16'(host_rx_ready), 16'd0);
        check("rx_nrxf", 16'(nRXF), 16'd0);
        for (int i = 0; i < 16; i++) read_byte($sformatf("rx_seq%0d", i), 8'(i));
        check("rx_drained_nrxf", 16'(nRXF), 16'd1);
        check("rx_drained_rdy", 16'(host_rx_ready), 16'd1);

        // Two bridge writes, host drains
        write_byte(8'hDE);
        write_byte(8'hAD);
        check("tx2_ntxe", 16'(nTXE), 16'd0);
        check("tx2_valid", 16'(host_tx_valid), 16'd1);
        check("tx2_head0", 16'(host_tx_data), 16'h00DE);
        host_tx_ready = 1'b1;
        tick(1);
        check("tx2_head1", 16'(host_tx_data), 16'h00AD);
        tick(1);
        host_tx_ready = 1'b0;
        check("tx2_empty", 16'(host_tx_valid), 16'd0);

        // Fill TX, overflow write is dropped and flagged
        for (int i = 0; i < 16; i++) write_byte(8'h30 + 8'(i));
        check("txf_ntxe", 16'(nTXE), 16'd1);
        check("txf_err0", 16'(proto_err), 16'd0);
        write_byte(8'h77);
        check("txf_err1", 16'(proto_err), 16'd1);
        check("txf_valid", 16'(host_tx_valid), 16'd1);
        check("txf_head", 16'(host_tx_data), 16'h0030);
`ifdef FT245_EMU_STATS_EN
        check("stat_rx", rx_byte_count, 16'd17);
        check("stat_tx", tx_byte_count, 16'd18);
`endif
        host_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("txf_seq%0d", i), 16'(host_tx_data), 16'(8'h30 + 8'(i)));
            tick(1);
        end
        host_tx_ready = 1'b0;
        check("txf_drained", 16'(host_tx_valid), 16'd0);

        // Read strobe on empty RX
        do_reset();
        check("err_cleared", 16'(proto_err), 16'd0);
        nRD = 1'b0;
        tick(4);
        check("empty_rd_err", 16'(proto_err), 16'd1);
        check("empty_rd_d", 16'(D), 16'h00FF);
        nRD = 1'b1;
        tick(4);

        // Reset asserted while D is being driven
        host_rx_data = 8'h3C; host_rx_valid = 1'b1;
        tick(1);
        host_rx_valid = 1'b0;
        tick(2);
        nRD = 1'b0;
        tick(3);
        check("mid_d", 16'(D), 16'h003C);
        RESET = 1'b1;
        #1;
        check("mid_rst_d", 16'(D), 16'h00FF);
        check("mid_rst_nrxf", 16'(nRXF), 16'd1);
        check("mid_rst_err", 16'(proto_err), 16'd0);
        nRD = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(2);
        check("mid_rx_dropped", 16'(nRXF), 16'd1);

        // nRD low while WR high: read wins, write edge ignored
        host_rx_data = 8'h5A; host_rx_valid = 1'b1;
        tick(1);
        host_rx_valid = 1'b0;
        tick(2);
        d_drv = 8'h11; d_en = 1'b0;
        WR = 1'b1;
        tick(1);
        nRD = 1'b0;
        tick(5);
        check("cf_err", 16'(proto_err), 16'd1);
        check("cf_d", 16'(D), 16'h005A);
        WR = 1'b0;
        tick(5);
        nRD = 1'b1;
        tick(8);
        check("cf_no_write", 16'(host_tx_valid), 16'd0);
        check("cf_rx_popped", 16'(nRXF), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
